// File: rtl/mdu_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The EXU side is the master; the MDU itself is the slave.
interface mdu_iter_if #(
  parameter int unsigned XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  modport master (
    output flush, in_valid, in_op, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV M-extension unit: one shift-add (multiply) or restoring step (divide) per cycle.
// Works on operand magnitudes and fixes signs when the result is captured.
module mdu_iter #(
  parameter int unsigned XLEN = 64,
  parameter bit          W_EN = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  mdu_iter_if.slave bus
);
  localparam bit          WOk  = (XLEN == 64) && W_EN;
  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam int unsigned PW   = 2 * XLEN;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d, m_q, m_d;
  logic [XLEN-1:0] a_q, a_d, res_q, res_d;
  logic            mul_q, mul_d, w_q, w_d, high_q, high_d, rem_q, rem_d;
  logic            neg1_q, neg1_d, neg2_q, neg2_d, fast_q, fast_d;

  logic dec_mul, dec_w, dec_high, dec_rem, dec_s1, dec_s2, dec_illegal;
  always_comb begin
    dec_mul = 1'b0; dec_w = 1'b0; dec_high = 1'b0; dec_rem = 1'b0;
    dec_s1 = 1'b0; dec_s2 = 1'b0; dec_illegal = 1'b0;
    unique case (bus.in_op)
      4'd0:  dec_mul = 1'b1;
      4'd1:  begin dec_mul = 1'b1; dec_high = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      4'd2:  begin dec_mul = 1'b1; dec_high = 1'b1; dec_s1 = 1'b1; end
      4'd3:  begin dec_mul = 1'b1; dec_high = 1'b1; end
      4'd4:  begin dec_s1 = 1'b1; dec_s2 = 1'b1; end
      4'd5:  ;
      4'd6:  begin dec_rem = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      4'd7:  dec_rem = 1'b1;
      4'd8:  begin dec_mul = 1'b1; dec_w = 1'b1; end
      4'd9:  begin dec_w = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      4'd10: dec_w = 1'b1;
      4'd11: begin dec_w = 1'b1; dec_rem = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      4'd12: begin dec_w = 1'b1; dec_rem = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_w && !WOk) dec_illegal = 1'b1;
  end

  logic [XLEN-1:0] s1, s2, mag1, mag2, src1_sx, fast_res;
  logic            neg1, neg2, div_zero, div_ovf, fast, accept;
  always_comb begin
    src1_sx = dec_w ? XLEN'($signed(bus.in_src1[31:0])) : bus.in_src1;
    s1 = bus.in_src1;
    s2 = bus.in_src2;
    if (dec_w) begin
      s1 = dec_s1 ? XLEN'($signed(bus.in_src1[31:0])) : XLEN'(bus.in_src1[31:0]);
      s2 = dec_s2 ? XLEN'($signed(bus.in_src2[31:0])) : XLEN'(bus.in_src2[31:0]);
    end
    neg1 = dec_s1 && s1[XLEN-1];
    neg2 = dec_s2 && s2[XLEN-1];
    mag1 = neg1 ? -s1 : s1;
    mag2 = neg2 ? -s2 : s2;
    div_zero = !dec_mul && (dec_w ? (bus.in_src2[31:0] == 32'd0) : (bus.in_src2 == '0));
    div_ovf  = !dec_mul && dec_s1 &&
               (dec_w ? (bus.in_src1[31:0] == 32'h8000_0000 && &bus.in_src2[31:0])
                      : (bus.in_src1 == {1'b1, {(XLEN-1){1'b0}}} && &bus.in_src2));
    fast = dec_illegal || div_zero || div_ovf;
    if (dec_illegal)   fast_res = '0;
    else if (div_zero) fast_res = dec_rem ? src1_sx : '1;
    else               fast_res = dec_rem ? '0 : src1_sx;
    accept = bus.in_valid && (state_q == StIdle) && !bus.flush;
  end

  logic [CntW-1:0] last;
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] quo, rmd, raw_res, fin_res;
  logic [XLEN:0]   trial;
  always_comb begin
    last    = w_q ? CntW'(32) : CntW'(XLEN);
    prod    = (neg1_q ^ neg2_q) ? -p_q : p_q;
    quo     = (neg1_q ^ neg2_q) ? -a_q : a_q;
    rmd     = neg1_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    raw_res = mul_q ? (high_q ? prod[PW-1:XLEN] : prod[XLEN-1:0]) : (rem_q ? rmd : quo);
    fin_res = w_q ? XLEN'($signed(raw_res[31:0])) : raw_res;
    trial   = {p_q[XLEN-1:0], a_q[XLEN-1]} - {1'b0, m_q[XLEN-1:0]};
  end

  always_comb begin
    p_d = p_q; m_d = m_q; a_d = a_q; res_d = res_q; cnt_d = cnt_q;
    mul_d = mul_q; w_d = w_q; high_d = high_q; rem_d = rem_q;
    neg1_d = neg1_q; neg2_d = neg2_q; fast_d = fast_q;
    case (state_q)
      StIdle: if (accept) begin
        mul_d = dec_mul; w_d = dec_w; high_d = dec_high; rem_d = dec_rem;
        neg1_d = neg1; neg2_d = neg2; fast_d = fast;
        cnt_d = '0;
        p_d   = '0;
        res_d = fast ? fast_res : res_q;
        m_d   = dec_mul ? PW'(mag1) : PW'(mag2);
        // W dividends sit at the top so the MSB-first loop needs only 32 steps.
        a_d   = dec_mul ? mag2 : (dec_w ? (mag1 << (XLEN - 32)) : mag1);
      end
      StBusy: begin
        if (fast_q || cnt_q == last) begin
          res_d = fast_q ? res_q : fin_res;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (mul_q) begin
            if (a_q[0]) p_d = p_q + m_q;
            m_d = m_q << 1;
            a_d = a_q >> 1;
          end else if (!trial[XLEN]) begin
            p_d = PW'(trial[XLEN-1:0]);
            a_d = {a_q[XLEN-2:0], 1'b1};
          end else begin
            p_d = PW'({p_q[XLEN-2:0], a_q[XLEN-1]});
            a_d = {a_q[XLEN-2:0], 1'b0};
          end
        end
      end
      default: ;
    endcase
    if (bus.flush) cnt_d = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy:  if (fast_q || cnt_q == last) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0; p_q <= '0; m_q <= '0; a_q <= '0; res_q <= '0;
      mul_q <= 1'b0; w_q <= 1'b0; high_q <= 1'b0; rem_q <= 1'b0;
      neg1_q <= 1'b0; neg2_q <= 1'b0; fast_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d; p_q <= p_d; m_q <= m_d; a_q <= a_d; res_q <= res_d;
      mul_q <= mul_d; w_q <= w_d; high_q <= high_d; rem_q <= rem_d;
      neg1_q <= neg1_d; neg2_q <= neg2_d; fast_q <= fast_d;
    end
  end

  always_comb begin
    bus.in_ready   = (state_q == StIdle);
    bus.out_valid  = (state_q == StDone);
    bus.busy       = (state_q != StIdle);
    bus.out_result = res_q;
  end
endmodule

// File: tb/tb_mdu_iter.sv
// Randomised bench for mdu_iter (XLEN=64) against a plain-arithmetic M-extension model.
module tb_mdu_iter;
  localparam logic [63:0] Min64 = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mdu_iter_if #(.XLEN(64)) bus ();
  mdu_iter #(.XLEN(64), .W_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic signed [127:0] sa, sb, za, zb, pr;
    logic [31:0] a32, b32, r32;
    sa = $signed({{64{a[63]}}, a}); sb = $signed({{64{b[63]}}, b});
    za = $signed({64'd0, a});       zb = $signed({64'd0, b});
    a32 = a[31:0]; b32 = b[31:0];
    case (op)
      4'd0: begin pr = za * zb; return pr[63:0]; end
      4'd1: begin pr = sa * sb; return pr[127:64]; end
      4'd2: begin pr = sa * zb; return pr[127:64]; end
      4'd3: begin pr = za * zb; return pr[127:64]; end
      4'd4: begin
        if (b == 64'd0) return '1;
        if (a == Min64 && b == '1) return a;
        return $signed(a) / $signed(b);
      end
      4'd5: return (b == 64'd0) ? '1 : a / b;
      4'd6: begin
        if (b == 64'd0) return a;
        if (a == Min64 && b == '1) return 64'd0;
        return $signed(a) % $signed(b);
      end
      4'd7: return (b == 64'd0) ? a : a % b;
      4'd8: begin r32 = a32 * b32; return sx32(r32); end
      4'd9: begin
        if (b32 == 32'd0) r32 = '1;
        else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
        else r32 = $signed(a32) / $signed(b32);
        return sx32(r32);
      end
      4'd10: begin r32 = (b32 == 32'd0) ? '1 : a32 / b32; return sx32(r32); end
      4'd11: begin
        if (b32 == 32'd0) r32 = a32;
        else if (a32 == 32'h8000_0000 && b32 == '1) r32 = 32'd0;
        else r32 = $signed(a32) % $signed(b32);
        return sx32(r32);
      end
      4'd12: begin r32 = (b32 == 32'd0) ? a32 : a32 % b32; return sx32(r32); end
      default: return 64'd0;
    endcase
  endfunction

  // Edges from accept to out_valid: 1 on the fast paths, else iteration count + 1.
  function automatic int ref_latency(input logic [3:0] op, input logic [63:0] a,
                                     input logic [63:0] b);
    if (op > 4'd12) return 1;
    if (op inside {4'd4, 4'd5, 4'd6, 4'd7}) begin
      if (b == 64'd0) return 1;
      if ((op == 4'd4 || op == 4'd6) && a == Min64 && b == '1) return 1;
      return 65;
    end
    if (op inside {4'd9, 4'd10, 4'd11, 4'd12}) begin
      if (b[31:0] == 32'd0) return 1;
      if ((op == 4'd9 || op == 4'd11) && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 1;
      return 33;
    end
    return (op == 4'd8) ? 33 : 65;
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [31:0] r0, r1;
    r0 = $urandom;
    r1 = $urandom;
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return Min64;
      4: return {r0, r1};
      5: return 64'($urandom_range(0, 20));
      6: return sx32(r0);
      default: return {r0, 32'h8000_0000};
    endcase
  endfunction

  task automatic start_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int waited = 0;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_eq("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = a;
    bus.in_src2  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_op    = 4'($urandom);
    bus.in_src1  = {32'($urandom), 32'($urandom)};
    bus.in_src2  = {32'($urandom), 32'($urandom)};
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int hold);
    logic [63:0] exp_res;
    int          lat;
    exp_res = ref_model(op, a, b);
    start_op(op, a, b);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(ref_latency(op, a, b)));
    check_eq({tag, "_res"}, bus.out_result, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_res"}, bus.out_result, exp_res);
      check_eq({tag, "_hold_rdy"}, 64'({bus.in_ready, bus.out_valid}), 64'b01);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_pop"}, 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [3:0]  rop;
    int          seen;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_op = 4'd0;
    bus.in_src1 = '0; bus.in_src2 = '0; bus.out_ready = 1'b0;
    #2;
    check_eq("rst_outputs", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
    check_eq("rst_result", bus.out_result, 64'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);

    run_op("mulhu_ones", 4'd3, '1, '1, 0);
    run_op("mulh_m1", 4'd1, '1, '1, 0);
    run_op("mul_m1", 4'd0, '1, '1, 0);
    run_op("mulhsu", 4'd2, '1, 64'd2, 0);
    run_op("div_m7", 4'd4, -64'sd7, 64'd2, 0);
    run_op("rem_m7", 4'd6, -64'sd7, 64'd2, 0);
    run_op("divw_ovf", 4'd9, 64'h0000_0001_8000_0000, '1, 0);
    run_op("divu_z", 4'd5, 64'd5, 64'd0, 0);
    run_op("remu_z", 4'd7, 64'd5, 64'd0, 0);
    run_op("div_ovf", 4'd4, Min64, '1, 0);
    run_op("illegal", 4'd14, 64'd9, 64'd3, 0);
    run_op("hold10", 4'd5, 64'd1000, 64'd7, 10);

    // Flush during a divide: no result, straight back to idle.
    start_op(4'd4, 64'd100_000, 64'd7);
    repeat (19) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check_eq("flush_idle", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check_eq("flush_no_valid", 64'(seen), 64'd0);
    run_op("mulw_after_flush", 4'd8, 64'h7FFF_FFFF, 64'd2, 0);

    // Flush beats a simultaneous request.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 4'd0; bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check_eq("flush_vs_accept", 64'({bus.in_ready, bus.busy}), 64'b10);

    // Flush beats out_ready in DONE and still lands in idle.
    start_op(4'd5, 64'd3, 64'd0);
    @(posedge clk);
    #1;
    check_eq("fast_done", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    check_eq("flush_in_done", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);

    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = rand_operand();
      rb  = rand_operand();
      run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
    end

    // Async reset mid-operation aborts and clears the result.
    start_op(4'd3, 64'd12345, 64'd678);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_midop", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
    check_eq("rst_midop_res", bus.out_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised, iterative multiply/divide unit for the RV64M/RV32M M-extension.
- Sits beside the single-cycle ALU in the EXU. It takes over every multiply, divide and remainder operation, so the ALU no longer needs combinational `*`, `/` or `%`.
- Uses one shift-add or restoring step per cycle, with valid/ready handshakes on input and output and a pipeline flush.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.
- W_EN, 1, enables W-suffixed ops (only meaningful when XLEN=64; forced to 0 when XLEN=32).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of any in-flight or pending op
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request
- in_op  input  4  op code (see Behaviour)
- in_src1  input  XLEN  operand 1 (multiplicand / dividend)
- in_src2  input  XLEN  operand 2 (multiplier / divisor)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_result  output  XLEN  result
- busy  output  1  high in BUSY or DONE

Behaviour:
- Op codes:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
  - 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW
  - 13-15 illegal.
  - With W_EN=0, codes 8-12 are also treated as illegal.
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept: an op is accepted on a rising edge where in_valid & in_ready & ~flush. Operands and op are registered at that edge; later changes to inputs are ignored.
- Iteration count N:
  - N = XLEN for full-width ops.
  - N = 32 for W ops.
  - A step counter counts N steps in BUSY.
- Latency: out_valid rises on the (N+1)th edge after the accept edge.
- Fast path: the unit goes IDLE->DONE on the edge after accept, with 1-cycle latency, for:
  - divide by zero: quotient all-ones, remainder = dividend.
  - signed overflow (most-negative / -1): quotient = dividend, remainder 0.
  - illegal op: result 0.
- Multiply:
  - Operands are sign/zero-extended per op to 2*XLEN, and the product is 2*XLEN wide.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Unsigned restoring division on magnitudes.
  - The quotient is negated if the operand signs differ (signed ops).
  - The remainder takes the sign of the dividend.
- W ops:
  - Operate on src[31:0] only, with the W extension rule of the op.
  - The 32-bit result is sign-extended to XLEN; this includes DIVUW and REMUW.
- DONE:
  - out_result is held stable until out_ready.
  - On out_valid & out_ready, the unit goes DONE->IDLE.
  - No same-cycle back-to-back accept: in_ready is low in DONE.
- Flush:
  - On any state, flush high at an edge sends the unit to IDLE and clears the step counter. out_valid is low from the next cycle.
  - Flush wins over a simultaneous accept or out_ready.
- Reset (async):
  - state = IDLE, counter = 0, out_result = 0.
  - out_valid = 0, busy = 0, in_ready = 1 after release.
- Reset asserted mid-op aborts immediately, with no result produced.
- Counter end: after exactly N steps the unit goes BUSY->DONE. The counter never wraps in BUSY.

Test Plan:
- XLEN=64, MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF -> out_result 0xFFFF_FFFF_FFFF_FFFE, out_valid exactly 65 cycles after accept.
- MULH src1=-1, src2=-1 -> 0; MUL same operands -> 1; MULHSU src1=-1, src2=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV src1=-7, src2=2 -> -3; REM same -> -1; DIVW src1=0x0000_0001_8000_0000, src2=-1 -> fast overflow path, 0xFFFF_FFFF_8000_0000 after 1 cycle.
- DIVU src1=5, src2=0 -> all-ones; REMU same -> 5; both with 1-cycle latency.
- Result held with out_ready=0 for 10 cycles -> out_result stable and in_ready low; out_ready=1 -> IDLE next cycle.
- Flush 20 cycles into a DIV -> out_valid never rises, in_ready=1 next cycle; new MULW src1=0x7FFF_FFFF, src2=2 -> 0xFFFF_FFFF_FFFF_FFFE after 33 cycles.
